// File: rtl/cpu_wrapper_v3.sv
// cpu_wrapper_v3: 8-bit five-stage (IF/ID/EX/MEM/WB) pipelined CPU with a unified
// 256x8 memory, four registers, I/O ports and one edge-triggered interrupt.

module cpu_pc (
   input  logic       clk,
   input  logic       rstn,
   input  logic [7:0] reset_vec,
   input  logic [7:0] pc_next,
   output logic [7:0] pc_current
);
   // program counter; reloads from the reset vector while held in reset
   always_ff @(posedge clk) begin
      if (!rstn) pc_current <= reset_vec;
      else       pc_current <= pc_next;
   end
endmodule

module cpu_regfile (
   input  logic       clk,
   input  logic       rstn,
   input  logic       we,
   input  logic [1:0] waddr,
   input  logic [7:0] wdata,
   input  logic [1:0] raddr_a,
   input  logic [1:0] raddr_b,
   output logic [7:0] rdata_a,
   output logic [7:0] rdata_b
);
   logic [7:0] regs [0:3];

   // register array, written from WB
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   // same-cycle WB value is visible to ID
   assign rdata_a = (we && (waddr == raddr_a)) ? wdata : regs[raddr_a];
   assign rdata_b = (we && (waddr == raddr_b)) ? wdata : regs[raddr_b];
endmodule

module cpu_mem (
   input  logic       clk,
   input  logic [7:0] f_addr,
   input  logic [7:0] d_addr,
   input  logic       d_we,
   input  logic [7:0] d_wdata,
   output logic [7:0] f_ins,
   output logic [7:0] f_imm,
   output logic [7:0] d_rdata,
   output logic [7:0] vec_reset,
   output logic [7:0] vec_irq
);
   logic [7:0] mem [0:255];
   logic [7:0] f_addr1_s;

   assign f_addr1_s = f_addr + 8'd1;
   assign f_ins     = mem[f_addr];
   assign f_imm     = mem[f_addr1_s];
   assign d_rdata   = mem[d_addr];
   assign vec_reset = mem[8'd0];
   assign vec_irq   = mem[8'd1];

   // data-port write from the MEM stage
   always_ff @(posedge clk) begin
      if (d_we) mem[d_addr] <= d_wdata;
   end
endmodule

module cpu_wrapper_v3 (
   input  logic       clk,
   input  logic       rstn,
   input  logic [7:0] I_Port,
   input  logic       int_sig,
   output logic [7:0] O_Port
);
   localparam logic [7:0] NOP_INS = 8'h00;

   function automatic logic is_load(input logic [3:0] op, input logic [1:0] ra);
      return (op == 4'd6 && ra == 2'd1) || (op == 4'd12 && ra == 2'd1) || (op == 4'd13);
   endfunction

   function automatic logic is_ctrl(input logic [3:0] op);
      return (op == 4'd7) || (op == 4'd11);
   endfunction

   function automatic logic writes_reg(input logic [3:0] op, input logic [1:0] ra);
      logic r;
      case (op)
         4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd13: r = 1'b1;
         4'd6:    r = (ra == 2'd1);
         4'd12:   r = (ra == 2'd0) || (ra == 2'd1);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [1:0] dest_of(input logic [3:0] op, input logic [1:0] ra,
                                          input logic [1:0] rb);
      logic [1:0] d;
      case (op)
         4'd6, 4'd12, 4'd13: d = rb;
         default:            d = ra;
      endcase
      return d;
   endfunction

   function automatic logic uses_a(input logic [3:0] op);
      return (op >= 4'd2 && op <= 4'd5) || (op == 4'd13) || (op == 4'd14);
   endfunction

   function automatic logic uses_b(input logic [3:0] op, input logic [1:0] ra);
      logic r;
      case (op)
         4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd14: r = 1'b1;
         4'd6:    r = (ra == 2'd0);
         4'd12:   r = (ra == 2'd2);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   logic [7:0] pc_s, pc_next_s, f_ins_s, f_imm_s, vec_reset_s, vec_irq_s, d_rdata_s;
   logic [7:0] rd_a_s, rd_b_s;
   logic [7:0] ifd_ins_r, ifd_imm_r, ifd_ins_nxt_s, ifd_imm_nxt_s;
   logic [7:0] ide_ins_r, ide_imm_r, ide_a_r, ide_b_r;
   logic [7:0] ide_ins_nxt_s, ide_imm_nxt_s, ide_a_nxt_s, ide_b_nxt_s;
   logic       exm_rw_r, exm_ld_r, exm_st_r, exm_out_r;
   logic [1:0] exm_rd_r;
   logic [7:0] exm_res_r, exm_addr_r, exm_wdata_r;
   logic       mwb_rw_r, mwb_out_r;
   logic [1:0] mwb_rd_r;
   logic [7:0] mwb_res_r;
   logic       int_prev_r, pend_r, en_r;
   logic [7:0] ret_r;
   logic [7:0] fa_s, fb_s, ex_res_s, ex_addr_s, ex_target_s;
   logic       ex_ctrl_s, ex_rti_s, stall_s, take_s;
   logic [3:0] ex_op_s, id_op_s;
   logic [1:0] ex_ra_s, ex_rb_s, id_ra_s, id_rb_s;

   assign ex_op_s = ide_ins_r[7:4];
   assign ex_ra_s = ide_ins_r[3:2];
   assign ex_rb_s = ide_ins_r[1:0];
   assign id_op_s = ifd_ins_r[7:4];
   assign id_ra_s = ifd_ins_r[3:2];
   assign id_rb_s = ifd_ins_r[1:0];

   cpu_pc PC (
      .clk(clk), .rstn(rstn), .reset_vec(vec_reset_s), .pc_next(pc_next_s), .pc_current(pc_s)
   );

   cpu_regfile regfile_inst (
      .clk(clk), .rstn(rstn), .we(mwb_rw_r), .waddr(mwb_rd_r), .wdata(mwb_res_r),
      .raddr_a(id_ra_s), .raddr_b(id_rb_s), .rdata_a(rd_a_s), .rdata_b(rd_b_s)
   );

   cpu_mem mem_inst (
      .clk(clk), .f_addr(pc_s), .d_addr(exm_addr_r), .d_we(exm_st_r & rstn),
      .d_wdata(exm_wdata_r), .f_ins(f_ins_s), .f_imm(f_imm_s), .d_rdata(d_rdata_s),
      .vec_reset(vec_reset_s), .vec_irq(vec_irq_s)
   );

   // EX: operand forwarding (MEM stage first, then WB) and result/address/target
   always_comb begin
      fa_s = ide_a_r;
      fb_s = ide_b_r;
      if (exm_rw_r && !exm_ld_r && (exm_rd_r == ex_ra_s))  fa_s = exm_res_r;
      else if (mwb_rw_r && (mwb_rd_r == ex_ra_s))          fa_s = mwb_res_r;
      else                                                 fa_s = ide_a_r;
      if (exm_rw_r && !exm_ld_r && (exm_rd_r == ex_rb_s))  fb_s = exm_res_r;
      else if (mwb_rw_r && (mwb_rd_r == ex_rb_s))          fb_s = mwb_res_r;
      else                                                 fb_s = ide_b_r;
      case (ex_op_s)
         4'd1:    ex_res_s = fb_s;
         4'd2:    ex_res_s = fa_s + fb_s;
         4'd3:    ex_res_s = fa_s - fb_s;
         4'd4:    ex_res_s = fa_s & fb_s;
         4'd5:    ex_res_s = fa_s | fb_s;
         4'd6:    ex_res_s = (ex_ra_s == 2'd1) ? I_Port : fb_s;
         4'd12:   ex_res_s = ide_imm_r;
         default: ex_res_s = 8'h00;
      endcase
      ex_addr_s   = (ex_op_s == 4'd12) ? ide_imm_r : fa_s;
      ex_ctrl_s   = is_ctrl(ex_op_s);
      ex_rti_s    = (ex_op_s == 4'd11);
      ex_target_s = ex_rti_s ? ret_r : fb_s;
   end

   // hazard detection: load-use stall and interrupt acceptance at a clean fetch boundary
   always_comb begin
      stall_s = 1'b0;
      if (is_load(ex_op_s, ex_ra_s)) begin
         stall_s = (uses_a(id_op_s) && (id_ra_s == dest_of(ex_op_s, ex_ra_s, ex_rb_s))) ||
                   (uses_b(id_op_s, id_ra_s) && (id_rb_s == dest_of(ex_op_s, ex_ra_s, ex_rb_s)));
      end else begin
         stall_s = 1'b0;
      end
      take_s = pend_r && !is_ctrl(ex_op_s) && !is_ctrl(id_op_s) && !stall_s;
   end

   // next PC and next IF/ID, ID/EX contents; redirect beats interrupt beats stall
   always_comb begin
      pc_next_s     = pc_s + ((f_ins_s[7:4] == 4'd12) ? 8'd2 : 8'd1);
      ifd_ins_nxt_s = f_ins_s;
      ifd_imm_nxt_s = f_imm_s;
      ide_ins_nxt_s = ifd_ins_r;
      ide_imm_nxt_s = ifd_imm_r;
      ide_a_nxt_s   = rd_a_s;
      ide_b_nxt_s   = rd_b_s;
      if (ex_ctrl_s) begin
         pc_next_s     = ex_target_s;
         ifd_ins_nxt_s = NOP_INS;
         ide_ins_nxt_s = NOP_INS;
      end else if (take_s) begin
         pc_next_s     = vec_irq_s;
         ifd_ins_nxt_s = NOP_INS;
      end else if (stall_s) begin
         pc_next_s     = pc_s;
         ifd_ins_nxt_s = ifd_ins_r;
         ifd_imm_nxt_s = ifd_imm_r;
         ide_ins_nxt_s = NOP_INS;
      end else begin
         ide_ins_nxt_s = ifd_ins_r;
      end
   end

   // pipeline registers and the registered output port
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ifd_ins_r <= NOP_INS;  ifd_imm_r <= 8'h00;
         ide_ins_r <= NOP_INS;  ide_imm_r <= 8'h00;  ide_a_r <= 8'h00;  ide_b_r <= 8'h00;
         exm_rw_r  <= 1'b0;  exm_ld_r <= 1'b0;  exm_st_r <= 1'b0;  exm_out_r <= 1'b0;
         exm_rd_r  <= 2'd0;  exm_res_r <= 8'h00;  exm_addr_r <= 8'h00;  exm_wdata_r <= 8'h00;
         mwb_rw_r  <= 1'b0;  mwb_out_r <= 1'b0;  mwb_rd_r <= 2'd0;  mwb_res_r <= 8'h00;
         O_Port    <= 8'h00;
      end else begin
         ifd_ins_r   <= ifd_ins_nxt_s;
         ifd_imm_r   <= ifd_imm_nxt_s;
         ide_ins_r   <= ide_ins_nxt_s;
         ide_imm_r   <= ide_imm_nxt_s;
         ide_a_r     <= ide_a_nxt_s;
         ide_b_r     <= ide_b_nxt_s;
         exm_rw_r    <= writes_reg(ex_op_s, ex_ra_s);
         exm_rd_r    <= dest_of(ex_op_s, ex_ra_s, ex_rb_s);
         exm_ld_r    <= (ex_op_s == 4'd12 && ex_ra_s == 2'd1) || (ex_op_s == 4'd13);
         exm_st_r    <= (ex_op_s == 4'd12 && ex_ra_s == 2'd2) || (ex_op_s == 4'd14);
         exm_out_r   <= (ex_op_s == 4'd6) && (ex_ra_s == 2'd0);
         exm_res_r   <= ex_res_s;
         exm_addr_r  <= ex_addr_s;
         exm_wdata_r <= fb_s;
         mwb_rw_r    <= exm_rw_r;
         mwb_rd_r    <= exm_rd_r;
         mwb_out_r   <= exm_out_r;
         mwb_res_r   <= exm_ld_r ? d_rdata_s : exm_res_r;
         if (mwb_out_r) O_Port <= mwb_res_r;
      end
   end

   // interrupt edge detect, pending/enable flags and saved return address
   always_ff @(posedge clk) begin
      if (!rstn) begin
         int_prev_r <= 1'b0;
         pend_r     <= 1'b0;
         en_r       <= 1'b1;
         ret_r      <= 8'h00;
      end else begin
         int_prev_r <= int_sig;
         if (take_s) begin
            pend_r <= 1'b0;
            en_r   <= 1'b0;
            ret_r  <= pc_s;
         end else begin
            if (int_sig && !int_prev_r && en_r) pend_r <= 1'b1;
            if (ex_rti_s) en_r <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_cpu_wrapper_v3.sv
// Directed bench for cpu_wrapper_v3: reset vector, loads/stores, forwarding,
// load-use stall, jump flush and interrupt entry/return.

module tb_cpu_wrapper_v3;
   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] I_Port;
   logic       int_sig;
   logic [7:0] O_Port;
   int         total = 0;
   int         bad = 0;

   cpu_wrapper_v3 dut (
      .clk(clk), .rstn(rstn), .I_Port(I_Port), .int_sig(int_sig), .O_Port(O_Port)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_mem();
      for (int i = 0; i < 256; i++) dut.mem_inst.mem[i] = 8'h00;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic hold_reset();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_pc(input string tag, input logic [7:0] t, input int lim);
      int i = 0;
      while (dut.PC.pc_current !== t && i < lim) begin
         @(negedge clk);
         i++;
      end
      check(tag, dut.PC.pc_current, t);
   endtask

   initial begin
      rstn = 1'b0; I_Port = 8'h00; int_sig = 1'b0;

      // program 1: reset vector, LDM, STD/LDD, STI/LDI
      clr_mem();
      dut.mem_inst.mem[0]  = 8'h01;
      dut.mem_inst.mem[1]  = 8'hC0; dut.mem_inst.mem[2]  = 8'hC6;
      dut.mem_inst.mem[3]  = 8'hC1; dut.mem_inst.mem[4]  = 8'h14;
      dut.mem_inst.mem[5]  = 8'hC3; dut.mem_inst.mem[6]  = 8'h27;
      dut.mem_inst.mem[7]  = 8'hC9; dut.mem_inst.mem[8]  = 8'hC8;
      dut.mem_inst.mem[9]  = 8'hC6; dut.mem_inst.mem[10] = 8'hC8;
      dut.mem_inst.mem[11] = 8'hE3; dut.mem_inst.mem[12] = 8'hD2;
      hold_reset();
      check("rst_pc", dut.PC.pc_current, 8'h01);
      check("rst_r0", dut.regfile_inst.regs[0], 8'h00);
      check("rst_r1", dut.regfile_inst.regs[1], 8'h00);
      check("rst_r2", dut.regfile_inst.regs[2], 8'h00);
      check("rst_r3", dut.regfile_inst.regs[3], 8'h00);
      check("rst_oport", O_Port, 8'h00);
      rstn = 1'b1;
      #1 check("pc_release", dut.PC.pc_current, 8'h01);
      cyc(1); check("pc_e1", dut.PC.pc_current, 8'h03);
      cyc(1); check("pc_e2", dut.PC.pc_current, 8'h05);
      cyc(1); check("pc_e3", dut.PC.pc_current, 8'h07);
      cyc(6); check("ldd_r2", dut.regfile_inst.regs[2], 8'h14);
      cyc(21);
      check("ldm_r0", dut.regfile_inst.regs[0], 8'hC6);
      check("ldm_r1", dut.regfile_inst.regs[1], 8'h14);
      check("ldm_r3", dut.regfile_inst.regs[3], 8'h27);
      check("ldi_r2", dut.regfile_inst.regs[2], 8'h27);
      check("std_mem200", dut.mem_inst.mem[200], 8'h14);
      check("sti_mem198", dut.mem_inst.mem[198], 8'h27);
      check("p1_oport", O_Port, 8'h00);

      // program 2: forwarding, OUT, load-use stall, IN
      clr_mem();
      dut.mem_inst.mem[0]    = 8'h10;
      dut.mem_inst.mem[8'h10] = 8'hC0; dut.mem_inst.mem[8'h11] = 8'h05;
      dut.mem_inst.mem[8'h12] = 8'h20;
      dut.mem_inst.mem[8'h13] = 8'h60;
      dut.mem_inst.mem[8'h14] = 8'hC5; dut.mem_inst.mem[8'h15] = 8'hAA;
      dut.mem_inst.mem[8'h16] = 8'h25;
      dut.mem_inst.mem[8'h17] = 8'h66;
      dut.mem_inst.mem[8'h18] = 8'h2A;
      dut.mem_inst.mem[8'hAA] = 8'h07;
      I_Port = 8'h21;
      hold_reset();
      check("p2_rst_oport", O_Port, 8'h00);
      rstn = 1'b1;
      cyc(4); check("p2_pc_e4", dut.PC.pc_current, 8'h16);
      cyc(2); check("stall_hold", dut.PC.pc_current, 8'h17);
      cyc(1); check("stall_resume", dut.PC.pc_current, 8'h18);
      cyc(15);
      check("fwd_r0", dut.regfile_inst.regs[0], 8'h0A);
      check("out_oport", O_Port, 8'h0A);
      check("loaduse_r1", dut.regfile_inst.regs[1], 8'h0E);
      check("in_r2", dut.regfile_inst.regs[2], 8'h42);

      // program 3: JMP flushes the two younger instructions
      clr_mem();
      I_Port = 8'h00;
      dut.mem_inst.mem[0]    = 8'h10;
      dut.mem_inst.mem[8'h10] = 8'hC2; dut.mem_inst.mem[8'h11] = 8'h40;
      dut.mem_inst.mem[8'h12] = 8'h72;
      dut.mem_inst.mem[8'h13] = 8'hC3; dut.mem_inst.mem[8'h14] = 8'h11;
      dut.mem_inst.mem[8'h15] = 8'hC0; dut.mem_inst.mem[8'h16] = 8'h22;
      dut.mem_inst.mem[8'h40] = 8'hC1; dut.mem_inst.mem[8'h41] = 8'h33;
      hold_reset();
      rstn = 1'b1;
      cyc(2); check("jmp_pc_e2", dut.PC.pc_current, 8'h13);
      cyc(2); check("jmp_target", dut.PC.pc_current, 8'h40);
      cyc(12);
      check("jmp_r1", dut.regfile_inst.regs[1], 8'h33);
      check("flush_r3", dut.regfile_inst.regs[3], 8'h00);
      check("flush_r0", dut.regfile_inst.regs[0], 8'h00);
      check("jmp_r2", dut.regfile_inst.regs[2], 8'h40);

      // program 4: interrupt entry/RTI, held level, second edge
      clr_mem();
      dut.mem_inst.mem[0]    = 8'h10;
      dut.mem_inst.mem[1]    = 8'h80;
      dut.mem_inst.mem[8'h10] = 8'hC0; dut.mem_inst.mem[8'h11] = 8'h00;
      dut.mem_inst.mem[8'h12] = 8'hC1; dut.mem_inst.mem[8'h13] = 8'h01;
      for (int a = 8'h14; a < 8'h1C; a++) dut.mem_inst.mem[a] = 8'h21;
      dut.mem_inst.mem[8'h1C] = 8'h60;
      dut.mem_inst.mem[8'h1D] = 8'hC1; dut.mem_inst.mem[8'h1E] = 8'h1F;
      dut.mem_inst.mem[8'h1F] = 8'h71;
      dut.mem_inst.mem[8'h80] = 8'hC3; dut.mem_inst.mem[8'h81] = 8'h01;
      dut.mem_inst.mem[8'h82] = 8'h2B;
      dut.mem_inst.mem[8'h83] = 8'hB0;
      hold_reset();
      rstn = 1'b1;
      cyc(5);
      int_sig = 1'b1;
      wait_pc("isr_entry", 8'h80, 10);
      cyc(28);
      check("no_retrigger", dut.regfile_inst.regs[2], 8'h01);
      int_sig = 1'b0;
      cyc(20);
      check("irq_r0_sum", dut.regfile_inst.regs[0], 8'h08);
      check("irq_oport", O_Port, 8'h08);
      check("isr_r3", dut.regfile_inst.regs[3], 8'h01);
      check("loop_r1", dut.regfile_inst.regs[1], 8'h1F);
      int_sig = 1'b1;
      cyc(3);
      int_sig = 1'b0;
      cyc(25);
      check("second_irq", dut.regfile_inst.regs[2], 8'h02);
      check("irq2_r0", dut.regfile_inst.regs[0], 8'h08);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cpu_wrapper_v3.md
Name: cpu_wrapper_v3

Overview:
- 8-bit, 5-stage pipelined CPU top level (IF, ID, EX, MEM, WB) with a unified 256x8 instruction/data memory and four 8-bit registers.
- Boots from the reset vector at mem[0].
- Talks to the outside world via an 8-bit input port, an 8-bit output port and an interrupt line.
- Required instance/signal names, for bench access: PC.pc_current, regfile_inst.regs[0..3], mem_inst.mem[0..255].

Parameters:
- none; widths fixed: data/address 8 bits, 4 registers, 256-byte memory.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rstn  input  1  reset rstn, synchronous, active-low; clock clk.
- I_Port  input  8  external input, read by IN.
- int_sig  input  1  interrupt request, active high.
- O_Port  output  8  registered output, written by OUT.

Behaviour:
- Reset (rstn=0 at posedge):
  - PC <= mem[0].
  - All pipeline registers flushed to NOP.
  - R0..R3 <= 0; O_Port <= 0; interrupt state cleared.
  - Memory contents are not reset.
  - Memory is zero-initialised at time 0 only; the bench may overwrite any location hierarchically at any time.
- Memory:
  - Two combinational read ports for fetch, mem[PC] and mem[PC+1] (address wraps modulo 256).
  - One data port: combinational read, synchronous write in MEM stage.
  - Fetch and data access never stall each other.
- Instruction byte encoding: [7:4] opcode, [3:2] ra, [1:0] rb. Two-byte instructions take their immediate from mem[PC+1]; PC advances by 2, otherwise by 1.
- Opcodes:
  - 0: NOP.
  - 1: MOV, R[ra] <= R[rb].
  - 2: ADD, R[ra] <= R[ra]+R[rb], mod 256.
  - 3: SUB, R[ra] <= R[ra]-R[rb], mod 256.
  - 4: AND, R[ra] <= R[ra]&R[rb].
  - 5: OR, R[ra] <= R[ra]|R[rb].
  - 6, ra=00: OUT, O_Port <= R[rb], updated when the instruction reaches WB.
  - 6, ra=01: IN, R[rb] <= I_Port sampled in EX.
  - 6, other ra: NOP.
  - 7: JMP, PC <= R[rb].
  - 11: RTI, PC <= saved return address; interrupts re-enabled.
  - 12 (two-byte):
    - ra=00: LDM, R[rb] <= imm.
    - ra=01: LDD, R[rb] <= mem[imm].
    - ra=10: STD, mem[imm] <= R[rb].
    - ra=11: NOP.
  - 13: LDI, R[rb] <= mem[R[ra]].
  - 14: STI, mem[R[ra]] <= R[rb].
  - 8, 9, 10, 15: NOP.
- Register file:
  - Written in WB.
  - Write-before-read: ID sees a value written in the same cycle.
- Forwarding: EX/MEM and MEM/WB results forward to EX operands, including the store-data and address operands of STD/STI/LDI.
- Load-use hazard: when LDD/LDI/IN is immediately followed by a consumer of its destination, stall IF/ID 1 cycle and insert a bubble.
- Memory RAW ordering: a store followed by a load to the same address returns the stored value, naturally, because MEM is in order.
- Control transfer: JMP/RTI resolve in EX; the two younger instructions are flushed to NOP.
- Interrupt:
  - A rising edge of int_sig while enabled sets a pending flag.
  - When pending and no control transfer is in EX, the return address (PC of the next unfetched instruction) is saved, older instructions are allowed to complete, and younger ones are flushed.
  - PC <= mem[1]; interrupts are disabled until RTI.
  - int_sig held high does not retrigger.
- Throughput: 1 instruction per cycle, excluding stalls and flushes. Result latency: a register is visible in regs 4 cycles after the instruction is fetched.

Test Plan:
- Reset vector: mem[0]=0x01, hold rstn low 2 cycles, release -> PC.pc_current=1 on the first cycle after release, then increments per instruction size.
- LDM back-to-back: C0 C6, C1 14, C3 27 from address 1 -> R0=198, R1=20, R3=39 within 10 cycles.
- STD/LDD: C9 C8 then C6 C8 immediately after -> mem[200]=20, R2=20.
- STI then LDI to the same pointer: E3 (mem[R0]=R3), then D2 -> mem[198]=39, R2=39. The full program above, ending with 0x00, completes within 30 cycles of reset release with mem[200]=20, mem[198]=39, R2=39.
- Forwarding and load-use: LDM R0,5; ADD R0,R0; OUT R0 -> O_Port=10. LDD R1,addr; ADD R1,R1 inserts exactly one stall cycle and yields the correct value.
- Control/interrupt:
  - JMP R2 with R2=0x40 -> the two following instructions are not executed, fetch resumes at 0x40.
  - int_sig pulse with mem[1]=ISR -> PC=ISR; RTI returns to the interrupted stream with no instruction lost or duplicated.
